vga_frame_monitor: RTL and testbench

Receive-side counterpart of the VGA square drawer: consumes a one-pixel-per-clock VGA stream (3-bit R/G/B, HS, VS, BLANK_N) and recovers pixel coordinates from the sync/blank framing. It locates pixels of a target colour and reports, once per frame, their bounding box and pixel count. It also flags malformed lines and frames. It sits on the drawer's outputs, either as an on-chip self-check or as a bench-side checker feeding status LEDs/HEX displays.

---
 rtl/vga_frame_monitor.sv | 180 ++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA checker: recovers pixel coordinates from blank/sync framing,
// reports the bounding box and count of target-colour pixels once per frame.
module vga_frame_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [2:0]  TARGET_R = 3'b111,
  parameter logic [2:0]  TARGET_G = 3'b000,
  parameter logic [2:0]  TARGET_B = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  VGA_R,
  input  logic [2:0]  VGA_G,
  input  logic [2:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        VGA_BLANK_N,
  output logic [9:0]  box_x_min,
  output logic [9:0]  box_x_max,
  output logic [8:0]  box_y_min,
  output logic [8:0]  box_y_max,
  output logic [18:0] hit_count,
  output logic        box_found,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] frame_count,
  output logic        hs_seen
);

  localparam logic [9:0] H_LEN = H_ACTIVE[9:0];
  localparam logic [8:0] V_LEN = V_ACTIVE[8:0];

  typedef enum logic {
    WAIT_ARM,
    ARMED
  } arm_state_t;

  arm_state_t arm_state;

  logic [2:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs, s_blank_n;
  logic        p_vs, p_blank_n;

  logic [9:0]  x_cnt;
  logic [8:0]  y_cnt;

  logic [9:0]  w_x_min, w_x_max;
  logic [8:0]  w_y_min, w_y_max;
  logic [18:0] w_hits;
  logic        w_found;
  logic        w_line_err;

  logic        line_end;
  logic        frame_edge;
  logic        hit;
  logic [8:0]  y_next;
  logic [8:0]  hit_y;
  logic        line_err_next;

  // Line-end accounting is folded in before the frame copy so a line that
  // closes on the same cycle as the VS edge still belongs to the old frame.
  always_comb begin
    line_end      = p_blank_n & ~s_blank_n;
    frame_edge    = p_vs & ~s_vs;
    hit           = s_blank_n && (s_r == TARGET_R) && (s_g == TARGET_G) && (s_b == TARGET_B);
    y_next        = y_cnt;
    line_err_next = w_line_err;
    if (line_end) begin
      if (y_cnt != '1) begin
        y_next = y_cnt + 9'd1;
      end
      if (x_cnt != H_LEN) begin
        line_err_next = 1'b1;
      end
    end
    hit_y = frame_edge ? '0 : y_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_r         <= '0;
      s_g         <= '0;
      s_b         <= '0;
      s_hs        <= 1'b1;
      s_vs        <= 1'b1;
      s_blank_n   <= 1'b0;
      p_vs        <= 1'b1;
      p_blank_n   <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      w_x_min     <= '0;
      w_x_max     <= '0;
      w_y_min     <= '0;
      w_y_max     <= '0;
      w_hits      <= '0;
      w_found     <= 1'b0;
      w_line_err  <= 1'b0;
      arm_state   <= WAIT_ARM;
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      hit_count   <= '0;
      box_found   <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      hs_seen     <= 1'b0;
    end else begin
      s_r       <= VGA_R;
      s_g       <= VGA_G;
      s_b       <= VGA_B;
      s_hs      <= VGA_HS;
      s_vs      <= VGA_VS;
      s_blank_n <= VGA_BLANK_N;
      p_vs      <= s_vs;
      p_blank_n <= s_blank_n;

      if (!s_hs) begin
        hs_seen <= 1'b1;
      end

      if (!s_blank_n) begin
        x_cnt <= '0;
      end else if (x_cnt != '1) begin
        x_cnt <= x_cnt + 10'd1;
      end

      frame_done <= 1'b0;
      if (frame_edge) begin
        if (arm_state == ARMED) begin
          box_x_min   <= w_x_min;
          box_x_max   <= w_x_max;
          box_y_min   <= w_y_min;
          box_y_max   <= w_y_max;
          hit_count   <= w_hits;
          box_found   <= w_found;
          line_err    <= line_err_next;
          frame_err   <= (y_next != V_LEN);
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
        arm_state  <= ARMED;
        y_cnt      <= '0;
        w_line_err <= 1'b0;
      end else begin
        y_cnt      <= y_next;
        w_line_err <= line_err_next;
      end

      // A hit on the boundary cycle opens the new frame's box at y = 0.
      if (hit) begin
        if (frame_edge || !w_found) begin
          w_x_min <= x_cnt;
          w_x_max <= x_cnt;
          w_y_min <= hit_y;
          w_y_max <= hit_y;
          w_hits  <= 19'd1;
          w_found <= 1'b1;
        end else begin
          if (x_cnt < w_x_min) w_x_min <= x_cnt;
          if (x_cnt > w_x_max) w_x_max <= x_cnt;
          if (hit_y < w_y_min) w_y_min <= hit_y;
          if (hit_y > w_y_max) w_y_max <= hit_y;
          if (w_hits != '1) w_hits <= w_hits + 19'd1;
        end
      end else if (frame_edge) begin
        w_x_min <= '0;
        w_x_max <= '0;
        w_y_min <= '0;
        w_y_max <= '0;
        w_hits  <= '0;
        w_found <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: directed frame table, hand-written corner
// sequences, and random frames checked against a coordinate-level model.
module tb_vga_frame_monitor;

  localparam int H = 8;
  localparam int V = 6;
  localparam logic [8:0] TGT = 9'b111_000_000;
  localparam logic [8:0] BG  = 9'b000_111_000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  vr, vg, vb;
  logic        vhs, vvs, vbn;
  logic [9:0]  box_x_min, box_x_max;
  logic [8:0]  box_y_min, box_y_max;
  logic [18:0] hit_count;
  logic        box_found, frame_done, line_err, frame_err, hs_seen;
  logic [15:0] frame_count;

  vga_frame_monitor #(
    .H_ACTIVE(H), .V_ACTIVE(V),
    .TARGET_R(3'b111), .TARGET_G(3'b000), .TARGET_B(3'b000)
  ) dut (
    .clk(clk), .reset(reset),
    .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
    .VGA_HS(vhs), .VGA_VS(vvs), .VGA_BLANK_N(vbn),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max),
    .hit_count(hit_count), .box_found(box_found), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err),
    .frame_count(frame_count), .hs_seen(hs_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xmin; int xmax; int ymin; int ymax;
    int count; int found; int lerr; int ferr;
  } rep_t;

  typedef struct {
    int n_lines; int bad_line; int bad_len;
    int rx0; int rx1; int ry0; int ry1;
    rep_t e;
  } vec_t;

  typedef struct { int x; int y; } pt_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_fc = 0;
  pt_t  hitq[$];
  int   lens[$];
  vec_t vecs[6];
  rep_t zero_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                       input logic hs, input logic vs, input logic bn);
    vr = r; vg = g; vb = b; vhs = hs; vvs = vs; vbn = bn;
    @(negedge clk);
  endtask

  function automatic vec_t mkvec(int nl, int bl, int blen, int x0, int x1, int y0, int y1,
                                 int exmin, int exmax, int eymin, int eymax,
                                 int ecnt, int efound, int elerr, int eferr);
    vec_t v;
    v.n_lines = nl; v.bad_line = bl; v.bad_len = blen;
    v.rx0 = x0; v.rx1 = x1; v.ry0 = y0; v.ry1 = y1;
    v.e = '{exmin, exmax, eymin, eymax, ecnt, efound, elerr, eferr};
    return v;
  endfunction

  // Streams one frame of lines; the model records hit coordinates and line lengths.
  task automatic drive_frame(input vec_t v, input bit rnd, input bit use_hs, input bit tail_gap);
    hitq.delete();
    lens.delete();
    for (int y = 0; y < v.n_lines; y++) begin
      int len;
      len = (y == v.bad_line) ? v.bad_len : H;
      lens.push_back(len);
      for (int x = 0; x < len; x++) begin
        logic [8:0] c;
        if (rnd) c = ($urandom_range(0, 3) == 0) ? TGT : 9'($urandom);
        else     c = (x >= v.rx0 && x <= v.rx1 && y >= v.ry0 && y <= v.ry1) ? TGT : BG;
        if (c == TGT) hitq.push_back(pt_t'{x, y});
        drive(c[8:6], c[5:3], c[2:0], 1'b1, 1'b1, 1'b1);
      end
      if (tail_gap || y != v.n_lines - 1) begin
        drive(3'd0, 3'd0, 3'd0, !use_hs, 1'b1, 1'b0);
        drive(3'd0, 3'd0, 3'd0, !use_hs, 1'b1, 1'b0);
        drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
      end
    end
  endtask

  function automatic rep_t model_report();
    rep_t r;
    r = '{default: 0};
    foreach (hitq[i]) begin
      if (i == 0) begin
        r.xmin = hitq[i].x; r.xmax = hitq[i].x;
        r.ymin = hitq[i].y; r.ymax = hitq[i].y;
      end else begin
        if (hitq[i].x < r.xmin) r.xmin = hitq[i].x;
        if (hitq[i].x > r.xmax) r.xmax = hitq[i].x;
        if (hitq[i].y < r.ymin) r.ymin = hitq[i].y;
        if (hitq[i].y > r.ymax) r.ymax = hitq[i].y;
      end
    end
    r.count = hitq.size();
    r.found = (hitq.size() > 0) ? 1 : 0;
    foreach (lens[i]) if (lens[i] != H) r.lerr = 1;
    r.ferr = (lens.size() != V) ? 1 : 0;
    return r;
  endfunction

  // VS falls during blanking; frame_done must rise exactly one edge after s_VS drops.
  task automatic vs_edge(input bit rep);
    logic f1, f2, f3;
    drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0); f1 = frame_done;
    drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0); f2 = frame_done;
    drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0); f3 = frame_done;
    drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    chk("done_early", f1, 1'b0);
    chk("done_pulse", f2, rep);
    chk("done_clear", f3, 1'b0);
    if (rep) exp_fc++;
  endtask

  task automatic check_report(input string tag, input rep_t e);
    chk({tag, ".x_min"}, box_x_min, e.xmin);
    chk({tag, ".x_max"}, box_x_max, e.xmax);
    chk({tag, ".y_min"}, box_y_min, e.ymin);
    chk({tag, ".y_max"}, box_y_max, e.ymax);
    chk({tag, ".hit_count"}, hit_count, e.count);
    chk({tag, ".box_found"}, box_found, e.found);
    chk({tag, ".line_err"}, line_err, e.lerr);
    chk({tag, ".frame_err"}, frame_err, e.ferr);
    chk({tag, ".frame_count"}, frame_count, exp_fc);
  endtask

  initial begin
    vec_t v;
    zero_r = '{default: 0};
    vecs[0] = mkvec(6, -1, 0, 2, 3, 1, 2,   2, 3, 1, 2,  4, 1, 0, 0);
    vecs[1] = mkvec(6,  3, 7, -1, -2, -1, -2, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[2] = mkvec(6, -1, 0, 0, 7, 0, 5,   0, 7, 0, 5, 48, 1, 0, 0);
    vecs[3] = mkvec(5, -1, 0, -1, -2, -1, -2, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[4] = mkvec(7, -1, 0, 7, 7, 6, 6,   7, 7, 6, 6,  1, 1, 0, 1);
    vecs[5] = mkvec(6,  0, 9, 0, 0, 0, 0,   0, 0, 0, 0,  1, 1, 1, 0);

    reset = 1'b1;
    vr = '0; vg = '0; vb = '0; vhs = 1'b1; vvs = 1'b1; vbn = 1'b0;
    @(negedge clk);
    drive(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    check_report("reset", zero_r);
    chk("reset.frame_done", frame_done, 1'b0);
    chk("reset.hs_seen", hs_seen, 1'b0);

    // Hits before the first VS edge belong to a partial frame and are dropped.
    drive_frame(vecs[0], 1'b0, 1'b0, 1'b1);
    vs_edge(1'b0);
    check_report("arm_only", zero_r);
    chk("arm_only.hs_seen", hs_seen, 1'b0);

    foreach (vecs[i]) begin
      drive_frame(vecs[i], 1'b0, 1'b1, 1'b1);
      vs_edge(1'b1);
      check_report($sformatf("vec%0d", i), vecs[i].e);
      if (i == 0) chk("hs_seen_set", hs_seen, 1'b1);
    end

    // Last hit at (7,5) with BLANK_N and VS falling together.
    v = mkvec(6, -1, 0, 7, 7, 5, 5, 7, 7, 5, 5, 1, 1, 0, 0);
    drive_frame(v, 1'b0, 1'b1, 1'b0);
    vs_edge(1'b1);
    check_report("coincident", v.e);

    for (int n = 0; n < 20; n++) begin
      v = mkvec(V - 1 + int'($urandom_range(0, 2)), int'($urandom_range(0, 11)),
                H - 1 + 2 * int'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_frame(v, 1'b1, 1'b1, 1'b1);
      vs_edge(1'b1);
      check_report($sformatf("rand%0d", n), model_report());
    end

    // Reset mid-frame: outputs clear at once, next VS edge only re-arms.
    v = mkvec(3, -1, 0, 1, 4, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_frame(v, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    drive(3'b111, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    exp_fc = 0;
    check_report("midreset", zero_r);
    chk("midreset.hs_seen", hs_seen, 1'b0);
    drive_frame(v, 1'b0, 1'b1, 1'b1);
    vs_edge(1'b0);
    check_report("rearm", zero_r);
    drive_frame(vecs[0], 1'b0, 1'b1, 1'b1);
    vs_edge(1'b1);
    check_report("after_rearm", vecs[0].e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
